// File: rtl/rv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rv_ctrl_pkg
// Shared constants for the branch resolution / PC sequencing block:
//   - branch funct3 encodings
//   - branch_ctrl FSM state encoding
//   - sequential fetch PC increment
// ---------------------------------------------------------------------------
package rv_ctrl_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_TRAP  = 2'd2
    } state_e;

    localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/branch_decide.sv
// ---------------------------------------------------------------------------
// branch_decide
// Combinational taken / not-taken decision for the execute-stage control
// transfer.
//   Branch  in  : instruction is a conditional branch
//   Jump    in  : instruction is JAL/JALR (always taken, wins over Branch)
//   Funct3  in  : branch condition field
//   BrEq    in  : comparator equality result
//   BrLt    in  : comparator less-than result (signedness chosen upstream)
//   Taken   out : control transfer is taken
// ---------------------------------------------------------------------------
module branch_decide
    import rv_ctrl_pkg::*;
(
    input  logic       Branch,
    input  logic       Jump,
    input  logic [2:0] Funct3,
    input  logic       BrEq,
    input  logic       BrLt,
    output logic       Taken
);

    always_comb begin
        Taken = 1'b0;
        if (Jump) begin
            Taken = 1'b1;
        end else if (Branch) begin
            // Signed and unsigned variants share one BrLt; the comparator
            // has already been steered by BrUn.
            case (Funct3)
                F3_BEQ:  Taken = BrEq;
                F3_BNE:  Taken = !BrEq;
                F3_BLT:  Taken = BrLt;
                F3_BGE:  Taken = !BrLt;
                F3_BLTU: Taken = BrLt;
                F3_BGEU: Taken = !BrLt;
                default: Taken = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// ---------------------------------------------------------------------------
// branch_ctrl
// Branch resolution and fetch PC sequencing. Redirects fetch on taken
// control transfers, flushes younger instructions for FLUSH_CYCLES
// unstalled cycles, and holds a misaligned target as a trap until acked.
//   clk, rst      in  : clock, synchronous active-high reset
//   Stall         in  : freezes PC, state and flush counter
//   ExValid       in  : execute instruction valid
//   Branch/Jump/Jalr/Funct3 in : control-transfer decode
//   BrEq, BrLt    in  : comparator results
//   Target        in  : ALU-computed target address
//   TrapAck       in  : trap handler acknowledge
//   BrUn          out : comparator unsigned select (Funct3[1])
//   PC            out : registered fetch address
//   PCSel         out : redirect taken this cycle (combinational)
//   Flush         out : registered IF/ID kill
//   MisalignTrap  out : registered, high while trapped
//   MisalignAddr  out : registered offending target
// ---------------------------------------------------------------------------
module branch_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned         DWIDTH       = 32,
    parameter logic [DWIDTH-1:0]   RESET_PC     = '0,
    parameter logic [DWIDTH-1:0]   TRAP_VEC     = 'h100,
    parameter int unsigned         FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Stall,
    input  logic              ExValid,
    input  logic              Branch,
    input  logic              Jump,
    input  logic              Jalr,
    input  logic [2:0]        Funct3,
    input  logic              BrEq,
    input  logic              BrLt,
    input  logic [DWIDTH-1:0] Target,
    input  logic              TrapAck,
    output logic              BrUn,
    output logic [DWIDTH-1:0] PC,
    output logic              PCSel,
    output logic              Flush,
    output logic              MisalignTrap,
    output logic [DWIDTH-1:0] MisalignAddr
);

    localparam logic [2:0]        CNT_INIT = 3'(FLUSH_CYCLES);
    localparam logic [DWIDTH-1:0] INC      = DWIDTH'(PC_INC);

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [DWIDTH-1:0] pc_q, pc_d;
    logic [DWIDTH-1:0] maddr_q, maddr_d;
    logic              flush_q, trap_q;
    logic              taken;
    logic [DWIDTH-1:0] eff_tgt;
    logic              misaligned;

    branch_decide u_decide (
        .Branch (Branch),
        .Jump   (Jump),
        .Funct3 (Funct3),
        .BrEq   (BrEq),
        .BrLt   (BrLt),
        .Taken  (taken)
    );

    assign BrUn       = Funct3[1];
    // JALR drops bit 0 of its target; bit 1 still flags 4-byte misalignment.
    assign eff_tgt    = Jalr ? {Target[DWIDTH-1:1], 1'b0} : Target;
    assign misaligned = eff_tgt[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        maddr_d = maddr_q;
        PCSel   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (!Stall) begin
                    if (ExValid && taken && !misaligned) begin
                        PCSel   = 1'b1;
                        pc_d    = eff_tgt;
                        cnt_d   = CNT_INIT;
                        state_d = ST_FLUSH;
                    end else if (ExValid && taken) begin
                        maddr_d = eff_tgt;
                        state_d = ST_TRAP;
                    end else begin
                        pc_d = pc_q + INC;
                    end
                end
            end
            ST_FLUSH: begin
                if (!Stall) begin
                    pc_d  = pc_q + INC;
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_TRAP: begin
                // The acknowledge is honoured even while the pipe is stalled.
                if (TrapAck) begin
                    pc_d    = TRAP_VEC;
                    cnt_d   = CNT_INIT;
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= 3'd0;
            pc_q    <= RESET_PC;
            maddr_q <= '0;
            flush_q <= 1'b0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            maddr_q <= maddr_d;
            flush_q <= (state_d == ST_FLUSH);
            trap_q  <= (state_d == ST_TRAP);
        end
    end

    assign PC           = pc_q;
    assign Flush        = flush_q;
    assign MisalignTrap = trap_q;
    assign MisalignAddr = maddr_q;

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Branch resolution and PC-sequencing stage that sits directly downstream of the branch comparator in the execute stage. It drives the comparator's `BrUn` select from the branch `funct3`, then combines the returned `BrEq`/`BrLt` with the branch or jump control to decide taken or not-taken. It owns the fetch PC register, redirects fetch on taken control transfers, and flushes younger instructions for a fixed number of cycles. A misaligned target is held as a trap until it is acknowledged.

## Interface
- `DWIDTH`, 32, datapath and PC width.
- `RESET_PC`, 0, PC value after reset.
- `TRAP_VEC`, 'h100, PC loaded after a misalignment trap is acknowledged.
- `FLUSH_CYCLES`, 2, number of unstalled cycles `Flush` stays high after a redirect; legal range 1..7.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `Stall` in 1: pipeline hold; when high, PC, state and counter are frozen.
- `ExValid` in 1: execute-stage instruction valid.
- `Branch` in 1: the execute instruction is a conditional branch.
- `Jump` in 1: the execute instruction is JAL or JALR.
- `Jalr` in 1: the jump is JALR; qualifies `Jump`.
- `Funct3` in 3: branch condition field.
- `BrEq` in 1: equality result from the comparator.
- `BrLt` in 1: less-than result from the comparator.
- `Target` in DWIDTH: target address computed by the ALU.
- `TrapAck` in 1: trap handler acknowledge.
- `BrUn` out 1: combinational, equals `Funct3[1]`; selects unsigned compare for the comparator.
- `PC` out DWIDTH: registered fetch address.
- `PCSel` out 1: combinational redirect-taken this cycle.
- `Flush` out 1: registered; kills IF/ID contents.
- `MisalignTrap` out 1: registered; held high while in TRAP.
- `MisalignAddr` out DWIDTH: registered; the offending target address.

## Operation
- **Taken rule:**
  - `Jump` is always taken.
  - `Branch` is taken per `Funct3`: 000 → BrEq; 001 → !BrEq; 100 → BrLt; 101 → !BrLt; 110 → BrLt; 111 → !BrLt.
  - `Funct3` 010 or 011 → not taken.
  - `Branch` and `Jump` both high → treated as `Jump`.
- **Effective target:** `Target` with bit 0 cleared when `Jalr` is high; otherwise `Target` unchanged. The target is misaligned when bit 1 of the effective target is 1 (4-byte alignment, no C extension).
- **State machine:** RUN, FLUSH, TRAP. Reset → RUN.
- **RUN:**
  - `PCSel` = `ExValid` & !`Stall` & taken & aligned.
  - If `PCSel`: PC ← effective target; counter ← FLUSH_CYCLES; go to FLUSH.
  - If `ExValid` & !`Stall` & taken & misaligned: PC holds; `MisalignAddr` ← effective target; go to TRAP.
  - Otherwise, when !`Stall`: PC ← PC + 4.
- **FLUSH:**
  - `Flush` = 1, and `ExValid` is ignored (the instruction is being flushed).
  - Each !`Stall` cycle: PC ← PC + 4 and the counter decrements.
  - When the counter reaches 1 and the cycle is unstalled, go to RUN.
- **TRAP:**
  - `MisalignTrap` = 1, PC holds, `ExValid` is ignored, and `TrapAck` overrides `Stall`.
  - On `TrapAck`: PC ← TRAP_VEC; counter ← FLUSH_CYCLES; go to FLUSH.
  - `TrapAck` outside TRAP is ignored.
- **PC arithmetic:** PC + 4 wraps modulo 2^DWIDTH with no overflow flag.
- **Stall priority:** `Stall` takes priority over a taken branch in RUN. No state is consumed; the branch is re-evaluated when `Stall` drops.

## Timing
- **Reset values:** PC = RESET_PC, `Flush` = 0, `MisalignTrap` = 0, `MisalignAddr` = 0, state = RUN, counter = 0.
- **Combinational outputs:** `BrUn`, `PCSel` and the taken decision are combinational from the inputs within the same cycle.
- **Redirect latency:** after a taken branch is seen in cycle N, PC shows the target in cycle N+1. `Flush` is high from N+1 for FLUSH_CYCLES unstalled cycles, plus any stalled cycles in between.
- **Trap latency:** a misaligned taken branch in cycle N raises `MisalignTrap` in N+1. `TrapAck` in cycle M gives PC = TRAP_VEC and `Flush` = 1 in M+1.
- **Reset mid-operation:** `rst` in any state (FLUSH with counter nonzero, TRAP) restores all reset values on the next edge.

## Structure
- **Package `rv_ctrl_pkg`:**
  - Funct3 constants: `F3_BEQ`, `F3_BNE`, `F3_BLT`, `F3_BGE`, `F3_BLTU`, `F3_BGEU`.
  - State encodings: `ST_RUN`, `ST_FLUSH`, `ST_TRAP`.
  - PC increment constant `PC_INC` = 4.
- **Sub-module `branch_decide`:** combinational; inputs `Branch`, `Jump`, `Funct3`, `BrEq`, `BrLt`; output `Taken`.
- **Top level:** `branch_ctrl` holds the PC register, FSM, flush counter and trap registers.

## Test plan
- **Reset:** assert `rst` for 2 cycles → PC = 0, `Flush` = 0, `MisalignTrap` = 0; then 3 free cycles → PC = 0xC.
- **BLT/BLTU signedness:** `Funct3` = 100 with `BrLt` = 1, `Target` = 0x40 → `BrUn` = 0, `PCSel` = 1, next PC = 0x40, `Flush` high for 2 cycles, PC = 0x48 after the flush. Repeat with `Funct3` = 110 → `BrUn` = 1.
- **Not-taken and reserved funct3:** BNE with `BrEq` = 1 → PC + 4 only. `Funct3` = 010 → not taken.
- **Stall during taken branch and during flush:** BEQ taken with `Stall` = 1 for 3 cycles → PC frozen and `PCSel` = 0; `Stall` drops → redirect occurs. A stall inside FLUSH extends `Flush` by the stall length.
- **Misaligned JALR:** `Target` = 0x1003 with `Jalr` = 1 → effective target 0x1002, `MisalignTrap` = 1, `MisalignAddr` = 0x1002, PC held. `TrapAck` → PC = 0x100, `Flush` high for 2 cycles.
- **Wrap and mid-flush reset:** PC = 0xFFFFFFFC → next PC = 0. `rst` asserted in the first FLUSH cycle → next cycle PC = RESET_PC and `Flush` = 0.
